// File: rtl/laser_pkg.sv
// Shared state encoding, coordinate/count types and the point-in-circle test
// used by the two-circle laser coverage scheduler.
package laser_pkg;

    localparam logic [2:0] ST_LOAD     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_SCAN     = 3'd2;
    localparam logic [2:0] ST_PASS_END = 3'd3;
    localparam logic [2:0] ST_REPORT   = 3'd4;

    typedef enum logic [2:0] {
        LOAD     = ST_LOAD,
        INIT     = ST_INIT,
        SCAN     = ST_SCAN,
        PASS_END = ST_PASS_END,
        REPORT   = ST_REPORT
    } state_t;

    typedef logic [3:0] coord_t;
    typedef logic [5:0] cnt_t;

    // Inclusive test: squared distance of 4-bit deltas fits in 9 bits without overflow.
    function automatic logic pt_inside(input coord_t ax, input coord_t ay,
                                       input coord_t bx, input coord_t by,
                                       input logic [8:0] rsq);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] dx2;
        logic [7:0] dy2;
        logic [8:0] sum;
        dx  = (ax > bx) ? ax - bx : bx - ax;
        dy  = (ay > by) ? ay - by : by - ay;
        dx2 = {4'd0, dx} * {4'd0, dx};
        dy2 = {4'd0, dy} * {4'd0, dy};
        sum = {1'b0, dx2} + {1'b0, dy2};
        return sum <= rsq;
    endfunction

endpackage

// File: rtl/laser_cov_unit.sv
// Combinational union-coverage check: a point counts if either the candidate
// circle or the fixed circle reaches it.
module laser_cov_unit
    import laser_pkg::*;
#(
    parameter int RADIUS_SQ = 16
) (
    input  logic [3:0] i_px,
    input  logic [3:0] i_py,
    input  logic [3:0] i_cx,
    input  logic [3:0] i_cy,
    input  logic [3:0] i_fx,
    input  logic [3:0] i_fy,
    output logic       o_covered
);

    localparam logic [8:0] RSQ = 9'(RADIUS_SQ);

    logic w_in_cand;
    logic w_in_fixed;

    assign w_in_cand  = pt_inside(i_px, i_py, i_cx, i_cy, RSQ);
    assign w_in_fixed = pt_inside(i_px, i_py, i_fx, i_fy, RSQ);
    assign o_covered  = w_in_cand | w_in_fixed;

endmodule

// File: rtl/laser_pass_sched.sv
// Two-circle coverage search: buffers one image of NPTS points, then runs
// alternating single-circle grid passes until coverage stops improving.
module laser_pass_sched
    import laser_pkg::*;
#(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16,
    parameter int MAX_PASS  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam int                IDX_W    = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cand;
    logic [7:0]       r_pass;
    coord_t           r_c1x, r_c1y, r_c2x, r_c2y;
    coord_t           r_best_x, r_best_y;
    cnt_t             r_acc, r_total, r_best_cnt;
    coord_t           r_out_c1x, r_out_c1y, r_out_c2x, r_out_c2y;
    logic             r_done;
    coord_t           r_mem_x [NPTS];
    coord_t           r_mem_y [NPTS];

    coord_t     w_px, w_py, w_mx, w_my, w_fx, w_fy;
    coord_t     w_c1x_cm, w_c1y_cm, w_c2x_cm, w_c2y_cm;
    logic       w_cov, w_last_pt, w_improved, w_finish;
    cnt_t       w_count;
    logic [7:0] w_pass_nxt;

    function automatic cnt_t sat_inc(input cnt_t a, input logic inc);
        return (inc && (a != '1)) ? a + cnt_t'(1) : a;
    endfunction

    assign w_px      = r_mem_x[r_idx];
    assign w_py      = r_mem_y[r_idx];
    assign w_last_pt = (r_idx == LAST_IDX);
    assign w_count   = sat_inc(r_acc, w_cov);

    // INIT scores the current pair; SCAN swaps in the candidate for the moving circle.
    always_comb begin
        w_mx = r_c1x;
        w_my = r_c1y;
        w_fx = r_c2x;
        w_fy = r_c2y;
        if (r_state == SCAN) begin
            w_mx = r_cand[3:0];
            w_my = r_cand[7:4];
            if (r_pass[0]) begin
                w_fx = r_c1x;
                w_fy = r_c1y;
            end
        end
    end

    laser_cov_unit #(.RADIUS_SQ(RADIUS_SQ)) u_cov (
        .i_px      (w_px),
        .i_py      (w_py),
        .i_cx      (w_mx),
        .i_cy      (w_my),
        .i_fx      (w_fx),
        .i_fy      (w_fy),
        .o_covered (w_cov)
    );

    assign w_pass_nxt = r_pass + 8'd1;
    assign w_improved = (r_best_cnt > r_total);
    assign w_finish   = ((w_pass_nxt >= 8'd2) && !w_improved) || (w_pass_nxt == 8'(MAX_PASS));
    assign w_c1x_cm   = r_pass[0] ? r_c1x    : r_best_x;
    assign w_c1y_cm   = r_pass[0] ? r_c1y    : r_best_y;
    assign w_c2x_cm   = r_pass[0] ? r_best_x : r_c2x;
    assign w_c2y_cm   = r_pass[0] ? r_best_y : r_c2y;

    always_ff @(posedge CLK) begin
        if (r_state == LOAD) begin
            r_mem_x[r_idx] <= X;
            r_mem_y[r_idx] <= Y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= LOAD;
            r_idx      <= '0;
            r_cand     <= '0;
            r_pass     <= '0;
            r_c1x      <= '0;
            r_c1y      <= '0;
            r_c2x      <= '0;
            r_c2y      <= '0;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_acc      <= '0;
            r_total    <= '0;
            r_best_cnt <= '0;
            r_out_c1x  <= '0;
            r_out_c1y  <= '0;
            r_out_c2x  <= '0;
            r_out_c2y  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_last_pt) begin
                        r_idx   <= '0;
                        r_c1x   <= '0;
                        r_c1y   <= '0;
                        r_c2x   <= '0;
                        r_c2y   <= '0;
                        r_pass  <= '0;
                        r_acc   <= '0;
                        r_state <= INIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                INIT: begin
                    if (w_last_pt) begin
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_cand     <= '0;
                        r_total    <= w_count;
                        r_best_cnt <= w_count;
                        r_best_x   <= r_c1x;
                        r_best_y   <= r_c1y;
                        r_state    <= SCAN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_acc <= w_count;
                    end
                end
                SCAN: begin
                    if (w_last_pt) begin
                        r_idx  <= '0;
                        r_acc  <= '0;
                        r_cand <= r_cand + 8'd1;
                        // Strict compare: ties keep the earlier candidate or the incumbent.
                        if (w_count > r_best_cnt) begin
                            r_best_cnt <= w_count;
                            r_best_x   <= r_cand[3:0];
                            r_best_y   <= r_cand[7:4];
                        end
                        if (r_cand == 8'hFF) begin
                            r_state <= PASS_END;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_acc <= w_count;
                    end
                end
                PASS_END: begin
                    r_c1x   <= w_c1x_cm;
                    r_c1y   <= w_c1y_cm;
                    r_c2x   <= w_c2x_cm;
                    r_c2y   <= w_c2y_cm;
                    r_total <= r_best_cnt;
                    r_pass  <= w_pass_nxt;
                    if (w_finish) begin
                        r_out_c1x <= w_c1x_cm;
                        r_out_c1y <= w_c1y_cm;
                        r_out_c2x <= w_c2x_cm;
                        r_out_c2y <= w_c2y_cm;
                        r_done    <= 1'b1;
                        r_state   <= REPORT;
                    end else begin
                        // The next moving circle is the one left untouched by this pass.
                        r_best_x <= w_pass_nxt[0] ? r_c2x : r_c1x;
                        r_best_y <= w_pass_nxt[0] ? r_c2y : r_c1y;
                        r_state  <= SCAN;
                    end
                end
                REPORT: begin
                    r_idx   <= '0;
                    r_state <= LOAD;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign C1X  = r_out_c1x;
    assign C1Y  = r_out_c1y;
    assign C2X  = r_out_c2x;
    assign C2Y  = r_out_c2y;
    assign DONE = r_done;

endmodule

// File: tb/tb_laser_pass_sched.sv
// Scoreboard bench for laser_pass_sched: three instances run directed images
// in parallel; a monitor pops expected centres and latency on every DONE.
module tb_laser_pass_sched;

    localparam int NP   = 40;
    localparam int PASS = 256 * NP + 1;
    localparam int LAT2 = NP + NP + 2 * PASS + 1;
    localparam int LAT3 = NP + NP + 3 * PASS + 1;

    typedef struct {
        logic [3:0] c1x;
        logic [3:0] c1y;
        logic [3:0] c2x;
        logic [3:0] c2y;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       t_rst [3] = '{1'b1, 1'b1, 1'b1};
    logic [3:0] t_x   [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] t_y   [3] = '{4'd0, 4'd0, 4'd0};
    logic [3:0] w_c1x [3];
    logic [3:0] w_c1y [3];
    logic [3:0] w_c2x [3];
    logic [3:0] w_c2y [3];
    logic       w_done[3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    laser_pass_sched #(.NPTS(NP), .RADIUS_SQ(16), .MAX_PASS(8)) dut_a (
        .CLK(clk), .RST(t_rst[0]), .X(t_x[0]), .Y(t_y[0]),
        .C1X(w_c1x[0]), .C1Y(w_c1y[0]), .C2X(w_c2x[0]), .C2Y(w_c2y[0]), .DONE(w_done[0]));

    laser_pass_sched #(.NPTS(NP), .RADIUS_SQ(16), .MAX_PASS(8)) dut_b (
        .CLK(clk), .RST(t_rst[1]), .X(t_x[1]), .Y(t_y[1]),
        .C1X(w_c1x[1]), .C1Y(w_c1y[1]), .C2X(w_c2x[1]), .C2Y(w_c2y[1]), .DONE(w_done[1]));

    laser_pass_sched #(.NPTS(NP), .RADIUS_SQ(16), .MAX_PASS(2)) dut_c (
        .CLK(clk), .RST(t_rst[2]), .X(t_x[2]), .Y(t_y[2]),
        .C1X(w_c1x[2]), .C1Y(w_c1y[2]), .C2X(w_c2x[2]), .C2Y(w_c2y[2]), .DONE(w_done[2]));

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pt(input int kind, input int i);
        case (kind)
            1:       return {4'd3, 4'd3};
            2:       return (i < 20) ? {4'd2, 4'd2}  : {4'd12, 4'd12};
            default: return (i < 20) ? {4'd13, 4'd2} : {4'd2, 4'd13};
        endcase
    endfunction

    task automatic push_exp(input int u, input int a, input int b, input int c, input int d,
                            input int lat);
        exp_t e;
        e.c1x = 4'(a);
        e.c1y = 4'(b);
        e.c2x = 4'(c);
        e.c2y = 4'(d);
        e.lat = lat;
        case (u)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int u, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
        case (u)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Caller is just after an edge; point 0 is taken by the next rising edge.
    task automatic load_img(input int u, input int kind);
        logic [7:0] v;
        for (int i = 0; i < NP; i++) begin
            v      = pt(kind, i);
            t_x[u] = v[7:4];
            t_y[u] = v[3:0];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int u, input string tag);
        int k = 0;
        while (w_done[u] !== 1'b1 && k < 40000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (w_done[u] !== 1'b1) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    // Monitor: cycle counting per instance, scoreboard pop on DONE, hold checks otherwise.
    initial begin
        int   cnt  [3];
        logic prevd[3];
        exp_t held [3];
        exp_t e;
        bit   ok;
        for (int u = 0; u < 3; u++) begin
            cnt[u]   = 0;
            prevd[u] = 1'b0;
            held[u]  = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
        end
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 3; u++) begin
                if (t_rst[u]) begin
                    cnt[u]   = 0;
                    prevd[u] = 1'b0;
                    held[u]  = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
                end else begin
                    cnt[u]++;
                    if (w_done[u] === 1'b1) begin
                        chk($sformatf("u%0d_done_one_cycle", u), int'(prevd[u]), 0);
                        pop_exp(u, ok, e);
                        if (!ok) begin
                            chk($sformatf("u%0d_unexpected_done", u), 1, 0);
                        end else begin
                            chk($sformatf("u%0d_c1", u), {w_c1x[u], w_c1y[u]}, {e.c1x, e.c1y});
                            chk($sformatf("u%0d_c2", u), {w_c2x[u], w_c2y[u]}, {e.c2x, e.c2y});
                            chk($sformatf("u%0d_latency", u), cnt[u] + 1, e.lat);
                            held[u] = e;
                        end
                        cnt[u] = -1;
                    end else if (cnt[u] % 1024 == 0) begin
                        chk($sformatf("u%0d_hold", u),
                            {w_c1x[u], w_c1y[u], w_c2x[u], w_c2y[u]},
                            {held[u].c1x, held[u].c1y, held[u].c2x, held[u].c2y});
                    end
                    prevd[u] = w_done[u];
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d_reset_outs", u),
                {w_c1x[u], w_c1y[u], w_c2x[u], w_c2y[u]}, 0);
            chk($sformatf("u%0d_reset_done", u), int'(w_done[u]), 0);
        end
        @(negedge clk);
        fork
            begin
                // Two images back-to-back; garbage on the REPORT cycle must not be taken.
                t_rst[0] = 1'b0;
                push_exp(0, 1, 0, 0, 0, LAT2);
                load_img(0, 1);
                wait_done(0, "a_img1");
                t_x[0] = 4'd8;
                t_y[0] = 4'd8;
                push_exp(0, 12, 8, 0, 0, LAT2);
                @(posedge clk);
                #1;
                load_img(0, 2);
                wait_done(0, "a_img2");
            end
            begin
                t_rst[1] = 1'b0;
                push_exp(1, 10, 0, 2, 9, LAT3);
                load_img(1, 3);
                wait_done(1, "b_img1");
            end
            begin
                t_rst[2] = 1'b0;
                push_exp(2, 10, 0, 2, 9, LAT2);
                load_img(2, 3);
                wait_done(2, "c_img1");
                @(posedge clk);
                #1;
                load_img(2, 3);
                repeat (2000) @(posedge clk);
                @(negedge clk);
                #2;
                t_rst[2] = 1'b1;
                #1;
                chk("c_async_rst_outs", {w_c1x[2], w_c1y[2], w_c2x[2], w_c2y[2]}, 0);
                chk("c_async_rst_done", int'(w_done[2]), 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                t_rst[2] = 1'b0;
                push_exp(2, 10, 0, 2, 9, LAT2);
                load_img(2, 3);
                wait_done(2, "c_img2");
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
